// File: rtl/app_rd_to_fifo.sv
// Purpose: capture DDR read-return beats, buffer them, and serialise each beat LSB-word-first onto a valid/ready port.
// Latency: a beat written at edge N is presented on dout after edge N and can be accepted at edge N+1; one word per cycle sustained.
// Backpressure: dout_ready stalls only the serialiser; the controller side cannot stall, so rd_credit_ok gates new reads on free space.
module app_rd_to_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 128,
    parameter int OW    = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          rd_issue,
    output logic          rd_credit_ok,
    input  logic [DW-1:0] app_rd_data,
    input  logic          app_rd_data_valid,
    input  logic          app_rd_data_end,
    output logic [OW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [AW:0]   outstanding,
    output logic          err_unsolicited,
    output logic          err_overflow,
    output logic          err_proto
);

    localparam int WPB = DW / OW;
    localparam int WIW = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [WIW-1:0] LAST_W  = WIW'(WPB - 1);

    // Beat storage viewed as WPB words so the serialiser can index words directly.
    logic [WPB-1:0][OW-1:0] mem [DEPTH];

    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    occ;
    logic [WIW-1:0] word_idx;

    logic           full;
    logic           push;
    logic           pop;
    logic           ret;
    logic [AW+1:0]  credit_sum;

    // Full is taken from the registered occupancy, so a beat arriving in the
    // same cycle as the final-word pop of a full FIFO is still dropped.
    assign full       = (occ == DEPTH_C);
    assign push       = app_rd_data_valid & ~full;
    assign pop        = dout_valid & dout_ready & (word_idx == LAST_W);
    assign ret        = app_rd_data_valid & (outstanding != '0);

    // Credit uses registers only so the dispatcher sees no combinational path from its own issue.
    assign credit_sum   = {1'b0, outstanding} + {1'b0, occ};
    assign rd_credit_ok = resetn & (credit_sum < {1'b0, DEPTH_C});

    assign dout_valid = (occ != '0);
    assign dout       = mem[rd_ptr][word_idx];

    // Beat storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= app_rd_data;
        end
    end

    // FIFO pointers, occupancy and the word position within the head beat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            word_idx <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                word_idx <= '0;
            end else if (dout_valid && dout_ready) begin
                word_idx <= word_idx + WIW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + (AW + 1)'(1);
                2'b01:   occ <= occ - (AW + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Issued-but-unreturned read count; an over-issue saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            outstanding <= '0;
        end else if (rd_issue && !ret) begin
            outstanding <= (outstanding == DEPTH_C) ? DEPTH_C : outstanding + (AW + 1)'(1);
        end else if (!rd_issue && ret) begin
            outstanding <= outstanding - (AW + 1)'(1);
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_unsolicited <= 1'b0;
            err_overflow    <= 1'b0;
            err_proto       <= 1'b0;
        end else if (app_rd_data_valid) begin
            if (outstanding == '0) err_unsolicited <= 1'b1;
            if (full)              err_overflow    <= 1'b1;
            if (!app_rd_data_end)  err_proto       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_app_rd_to_fifo.sv
// Purpose: directed self-checking bench for app_rd_to_fifo (table vectors plus hand-written sequences).
// Latency: inputs change 1ns after the rising edge; outputs are checked 1ns after the edge or at the falling edge.
// Backpressure: dout_ready is driven per vector; a scoreboard queue holds the words expected on accepted handshakes.
module tb_app_rd_to_fifo;

    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_issue;
    logic         rd_credit_ok;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic [15:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic [3:0]   outstanding;
    logic         err_unsolicited;
    logic         err_overflow;
    logic         err_proto;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];
    logic mon_en = 1'b0;

    app_rd_to_fifo #(.DEPTH(8), .AW(3), .DW(128), .OW(16)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .rd_issue          (rd_issue),
        .rd_credit_ok      (rd_credit_ok),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data_end   (app_rd_data_end),
        .dout              (dout),
        .dout_valid        (dout_valid),
        .dout_ready        (dout_ready),
        .outstanding       (outstanding),
        .err_unsolicited   (err_unsolicited),
        .err_overflow      (err_overflow),
        .err_proto         (err_proto)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         issue;
        logic         vld;
        logic         eop;
        logic         rdy;
        logic [127:0] data;
        logic         exp_dv;
        logic         chk_dout;
        logic [15:0]  exp_dout;
        logic [3:0]   exp_out;
        logic         exp_cr;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mkbeat(input logic [15:0] base);
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[i*16 +: 16] = base + 16'(i);
        return b;
    endfunction

    task automatic push_exp(input logic [127:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i*16 +: 16]);
    endtask

    task automatic drive(input logic iss, input logic v, input logic e,
                         input logic [127:0] d, input logic r);
        rd_issue          = iss;
        app_rd_data_valid = v;
        app_rd_data_end   = e;
        app_rd_data       = d;
        dout_ready        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain_n(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    // Scoreboard: every accepted word must match the next expected word.
    always @(negedge clk) begin
        if (mon_en && resetn && dout_valid && dout_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got %0h expected no word", dout);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL sb_word: got %0h expected %0h", dout, e);
                end
            end
        end
    end

    // Dispatcher rule: never issue without credit.
    always @(negedge clk) begin
        if (resetn && rd_issue) begin
            checks++;
            if (rd_credit_ok !== 1'b1) begin
                errors++;
                $display("FAIL issue_no_credit: got credit %0b expected 1", rd_credit_ok);
            end
        end
    end

    initial begin
        int gaps;
        logic [127:0] b;

        // Single read: issue, return one beat, stream 8 words out.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, '0,                   1'b0, 1'b0, 16'h0000, 4'd1, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, mkbeat(16'h0000),     1'b1, 1'b1, 16'h0000, 4'd0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, '0,                   1'b1, 1'b1, 16'h0001, 4'd0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, '0,                   1'b1, 1'b1, 16'h0002, 4'd0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, '0,                   1'b1, 1'b1, 16'h0003, 4'd0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, '0,                   1'b1, 1'b1, 16'h0004, 4'd0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, '0,                   1'b1, 1'b1, 16'h0005, 4'd0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, '0,                   1'b1, 1'b1, 16'h0006, 4'd0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, '0,                   1'b1, 1'b1, 16'h0007, 4'd0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, '0,                   1'b0, 1'b0, 16'h0000, 4'd0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, '0,                   1'b0, 1'b0, 16'h0000, 4'd0, 1'b1};

        // Reset held 3 cycles with a beat presented.
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, mkbeat(16'hDEAD), 1'b1);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_credit", 32'(rd_credit_ok), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_errs", {29'd0, err_unsolicited, err_overflow, err_proto}, 32'd0);
        resetn = 1'b1;
        idle_n(1);
        chk("post_rst_credit", 32'(rd_credit_ok), 32'd1);

        // Table-driven single read.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].issue, tbl[i].vld, tbl[i].eop, tbl[i].data, tbl[i].rdy);
            chk($sformatf("tbl%0d_dv", i), 32'(dout_valid), 32'(tbl[i].exp_dv));
            if (tbl[i].chk_dout) chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].exp_dout));
            chk($sformatf("tbl%0d_outst", i), 32'(outstanding), 32'(tbl[i].exp_out));
            chk($sformatf("tbl%0d_credit", i), 32'(rd_credit_ok), 32'(tbl[i].exp_cr));
        end
        idle_n(1);

        // Credit exhaustion.
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("exh_outst8", 32'(outstanding), 32'd8);
        chk("exh_credit_after8", 32'(rd_credit_ok), 32'd0);
        for (int k = 0; k < 8; k++) begin
            b = mkbeat(16'h1000 + 16'(k * 16));
            push_exp(b);
            drive(1'b0, 1'b1, 1'b1, b, 1'b0);
        end
        chk("exh_outst0", 32'(outstanding), 32'd0);
        chk("exh_credit_full", 32'(rd_credit_ok), 32'd0);
        chk("exh_dv", 32'(dout_valid), 32'd1);
        drain_n(7);
        chk("exh_credit_7w", 32'(rd_credit_ok), 32'd0);
        drain_n(1);
        chk("exh_credit_8w", 32'(rd_credit_ok), 32'd1);
        drain_n(56);
        chk("exh_drained_dv", 32'(dout_valid), 32'd0);
        chk("exh_q_empty", 32'(exp_q.size()), 32'd0);
        idle_n(1);

        // Simultaneous issue/return at outstanding=3, 20 beats through the wrap, no bubbles.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("str_outst3", 32'(outstanding), 32'd3);
        gaps = 0;
        for (int k = 0; k < 23; k++) begin
            b = mkbeat(16'h2000 + 16'(k * 16));
            push_exp(b);
            drive(k < 20, 1'b1, 1'b1, b, 1'b1);
            if (!dout_valid) gaps++;
            if (k < 20) chk($sformatf("str_outst_b%0d", k), 32'(outstanding), 32'd3);
            for (int j = 0; j < 7; j++) begin
                drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
                if (!dout_valid) gaps++;
            end
        end
        drain_n(1);
        chk("str_gaps", 32'(gaps), 32'd0);
        chk("str_outst0", 32'(outstanding), 32'd0);
        chk("str_dv_end", 32'(dout_valid), 32'd0);
        chk("str_q_empty", 32'(exp_q.size()), 32'd0);
        chk("str_no_errs", {29'd0, err_unsolicited, err_overflow, err_proto}, 32'd0);

        // Unsolicited beat is flagged and still delivered.
        b = mkbeat(16'h3000);
        push_exp(b);
        drive(1'b0, 1'b1, 1'b1, b, 1'b0);
        chk("uns_flag", 32'(err_unsolicited), 32'd1);
        chk("uns_no_ovf", 32'(err_overflow), 32'd0);
        drain_n(8);
        chk("uns_delivered", 32'(exp_q.size()), 32'd0);

        // Fill to 8, then a 9th beat must be dropped.
        for (int k = 0; k < 8; k++) begin
            b = mkbeat(16'h4000 + 16'(k * 16));
            push_exp(b);
            drive(1'b0, 1'b1, 1'b1, b, 1'b0);
        end
        chk("ovf_not_yet", 32'(err_overflow), 32'd0);
        drive(1'b0, 1'b1, 1'b1, mkbeat(16'h4F00), 1'b0);
        chk("ovf_flag", 32'(err_overflow), 32'd1);
        drain_n(64);
        chk("ovf_dv_end", 32'(dout_valid), 32'd0);
        chk("ovf_q_empty", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        // Protocol error and reset mid-beat.
        resetn = 1'b0;
        idle_n(1);
        resetn = 1'b1;
        chk("pr_errs_clear", {29'd0, err_unsolicited, err_overflow, err_proto}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, mkbeat(16'h5000), 1'b0);
        chk("pr_flag", 32'(err_proto), 32'd1);
        chk("pr_stored_w0", 32'(dout), 32'h5000);
        drain_n(3);
        chk("pr_w3", 32'(dout), 32'h5003);
        resetn = 1'b0;
        idle_n(1);
        chk("mid_rst_dv", 32'(dout_valid), 32'd0);
        chk("mid_rst_errs", {29'd0, err_unsolicited, err_overflow, err_proto}, 32'd0);
        chk("mid_rst_outst", 32'(outstanding), 32'd0);
        resetn = 1'b1;
        drive(1'b0, 1'b1, 1'b1, mkbeat(16'h6000), 1'b0);
        chk("restart_w0", 32'(dout), 32'h6000);
        drain_n(1);
        chk("restart_w1", 32'(dout), 32'h6001);
        drain_n(7);
        chk("restart_dv_end", 32'(dout_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
